// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and the packet reader's state encoding.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POLL_AR,
      ST_POLL_R,
      ST_GAP,
      ST_DATA_AR,
      ST_DATA_R,
      ST_OUT
   } rd_state_t;

   // Anything other than OKAY is treated as a failed read.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_lite_pkt_reader.sv
// AXI4-Lite read master: polls a packet buffer's status word, then streams the
// pending packet out one word at a time with last/error marking.
//
// state   | meaning
// IDLE    | waiting for enable_i to start a status poll
// POLL_AR | status read address presented
// POLL_R  | waiting for status read data
// GAP     | back-off after an empty or bad poll
// DATA_AR | data word read address presented
// DATA_R  | waiting for data word
// OUT     | data word held on the stream until accepted
module axi_lite_pkt_reader
   import axi_lite_pkg::*;
#(
   parameter logic [31:0] STATUS_ADDR = 32'h0000_0000,
   parameter logic [31:0] DATA_BASE   = 32'h0000_0004,
   parameter logic [15:0] MAX_WORDS   = 16'd384,
   parameter logic [7:0]  POLL_GAP    = 8'd16
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic        enable_i,
   output logic [31:0] M_AXI_ARADDR,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY,
   output logic [31:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic        m_tuser,
   output logic [15:0] pkt_cnt_o,
   output logic        err_o
);

   rd_state_t   state_q, state_d;
   logic [31:0] araddr_q, araddr_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic [31:0] tdata_q, tdata_d;
   logic        tvalid_q, tvalid_d;
   logic        tlast_q, tlast_d;
   logic        tuser_q, tuser_d;
   logic        err_q, err_d;
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] len_q, len_d;
   logic [15:0] idx_q, idx_d;
   logic [7:0]  gap_q, gap_d;

   logic        ar_hs, r_hs, t_hs, r_err, len_big, poll_skip;

   assign ar_hs     = arvalid_q & M_AXI_ARREADY;
   assign r_hs      = rready_q & M_AXI_RVALID;
   assign t_hs      = tvalid_q & m_tready;
   assign r_err     = resp_is_err(M_AXI_RRESP);
   assign len_big   = M_AXI_RDATA[15:0] > MAX_WORDS;
   // A poll that yields nothing readable backs off instead of reading data.
   assign poll_skip = r_err | (M_AXI_RDATA[15:0] == 16'd0) | len_big;

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q   <= ST_IDLE;
         araddr_q  <= STATUS_ADDR;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         tdata_q   <= 32'd0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         tuser_q   <= 1'b0;
         err_q     <= 1'b0;
         pkt_cnt_q <= 16'd0;
         len_q     <= 16'd0;
         idx_q     <= 16'd0;
         gap_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         araddr_q  <= araddr_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         tdata_q   <= tdata_d;
         tvalid_q  <= tvalid_d;
         tlast_q   <= tlast_d;
         tuser_q   <= tuser_d;
         err_q     <= err_d;
         pkt_cnt_q <= pkt_cnt_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         gap_q     <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (enable_i) state_d = ST_POLL_AR;
         ST_POLL_AR: if (ar_hs) state_d = ST_POLL_R;
         ST_POLL_R:  if (r_hs) state_d = poll_skip ? ST_GAP : ST_DATA_AR;
         ST_GAP:     if (gap_q == 8'd0) state_d = ST_IDLE;
         ST_DATA_AR: if (ar_hs) state_d = ST_DATA_R;
         ST_DATA_R:  if (r_hs) state_d = ST_OUT;
         ST_OUT:     if (t_hs) state_d = tlast_q ? ST_IDLE : ST_DATA_AR;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      araddr_d  = araddr_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      tuser_d   = tuser_q;
      err_d     = 1'b0;
      pkt_cnt_d = pkt_cnt_q;
      len_d     = len_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
      unique case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               araddr_d  = STATUS_ADDR;
               arvalid_d = 1'b1;
            end
         end
         ST_POLL_AR, ST_DATA_AR: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         ST_POLL_R: begin
            if (r_hs) begin
               rready_d = 1'b0;
               err_d    = r_err | len_big;
               if (poll_skip) begin
                  gap_d = POLL_GAP;
               end else begin
                  len_d     = M_AXI_RDATA[15:0];
                  idx_d     = 16'd0;
                  araddr_d  = DATA_BASE;
                  arvalid_d = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
         end
         ST_DATA_R: begin
            if (r_hs) begin
               tdata_d  = M_AXI_RDATA;
               rready_d = 1'b0;
               tvalid_d = 1'b1;
               tlast_d  = (idx_q == len_q - 16'd1) | r_err;
               tuser_d  = r_err;
               err_d    = r_err;
            end
         end
         ST_OUT: begin
            if (t_hs) begin
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               tuser_d  = 1'b0;
               if (tlast_q) begin
                  if (!tuser_q) pkt_cnt_d = pkt_cnt_q + 16'd1;
               end else begin
                  idx_d     = idx_q + 16'd1;
                  araddr_d  = araddr_q + 32'd4;
                  arvalid_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;
   assign m_tdata       = tdata_q;
   assign m_tvalid      = tvalid_q;
   assign m_tlast       = tlast_q;
   assign m_tuser       = tuser_q;
   assign pkt_cnt_o     = pkt_cnt_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_axi_lite_pkt_reader.sv
// Bench for axi_lite_pkt_reader: behavioural AXI-Lite slave plus a packet-level
// reference of the beats, addresses, error pulses and packet count expected.
module tb_axi_lite_pkt_reader;

   localparam int MAX_WORDS = 384;
   localparam int POLL_GAP  = 16;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        enable = 1'b0;
   logic        arready = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = 32'd0;
   logic [1:0]  rresp = 2'b00;
   logic        tready = 1'b0;

   logic [31:0] araddr;
   logic        arvalid, rready;
   logic [31:0] tdata;
   logic        tvalid, tlast, tuser, err;
   logic [15:0] pkt_cnt;

   axi_lite_pkt_reader dut (
      .ACLK(aclk), .ARESETN(aresetn), .enable_i(enable),
      .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
      .m_tdata(tdata), .m_tvalid(tvalid), .m_tready(tready), .m_tlast(tlast), .m_tuser(tuser),
      .pkt_cnt_o(pkt_cnt), .err_o(err)
   );

   always #5 aclk = ~aclk;

   int n_cmp = 0;
   int n_fail = 0;

   // slave contents and policies
   logic [31:0] mem [0:63];
   logic [31:0] status_word = 32'd0;
   int          bad_word = -1;
   bit          rand_slv = 0;
   bit          rand_tready = 0;
   int          stall_beat = -1;
   int          stall_left = 0;

   // slave / observation state
   bit          rd_pend = 0;
   logic [31:0] rd_addr = 32'd0;
   int          rd_dly = 0;
   int          beat_idx = 0;
   int          cyc = 0;
   int          last_rhs_cyc = 0;
   int          r_hs_count = 0;
   int          ar_rise_cyc = 0;
   int          err_seen = 0;
   bit          data_ar_hs = 0;
   int          exp_pkt = 0;
   logic [31:0] ar_log[$];
   logic [33:0] beats[$];

   bit          p_arv = 0, p_arhs = 0, p_tv = 0, p_ths = 0, p_err = 0, p_tlast = 0, p_tuser = 0;
   logic [31:0] p_araddr = 32'd0, p_tdata = 32'd0;

   function automatic logic [31:0] slave_data(input logic [31:0] a);
      int i;
      if (a == 32'h0) return status_word;
      i = int'((a - 32'd4) >> 2);
      if (i < 64) return mem[i];
      return 32'hDEAD_0000;
   endfunction

   function automatic logic [1:0] slave_resp(input logic [31:0] a);
      if (a == 32'h0) return 2'b00;
      if (int'((a - 32'd4) >> 2) == bad_word) return 2'b10;
      return 2'b00;
   endfunction

   task automatic clear_model();
      rd_pend = 0; p_arv = 0; p_arhs = 0; p_tv = 0; p_ths = 0; p_err = 0;
      beats.delete(); ar_log.delete(); err_seen = 0; r_hs_count = 0;
      stall_left = 0; beat_idx = 0;
   endtask

   task automatic reset_dut();
      @(negedge aclk);
      aresetn = 0; arready = 0; rvalid = 0; tready = 1;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1;
      clear_model();
      exp_pkt = 0;
   endtask

   // One clock: observe outputs at negedge, drive slave/sink, account handshakes.
   task automatic step();
      bit arhs, rhs, ths;
      @(negedge aclk);
      if (p_arv && !p_arhs) begin
         n_cmp++;
         if (arvalid !== 1'b1 || araddr !== p_araddr) begin
            n_fail++;
            $display("FAIL ar_hold: got arvalid=%b addr=%h want 1 %h", arvalid, araddr, p_araddr);
         end
      end
      if (p_tv && !p_ths) begin
         n_cmp++;
         if (tvalid !== 1'b1 || tdata !== p_tdata || tlast !== p_tlast || tuser !== p_tuser) begin
            n_fail++;
            $display("FAIL t_hold: got v=%b d=%h l=%b u=%b want 1 %h %b %b",
                     tvalid, tdata, tlast, tuser, p_tdata, p_tlast, p_tuser);
         end
      end
      if (tvalid === 1'b1) begin
         n_cmp++;
         if (arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ahead: got arvalid=%b while beat pending want 0", arvalid);
         end
      end
      if (err === 1'b1) begin
         err_seen++;
         n_cmp++;
         if (p_err) begin
            n_fail++;
            $display("FAIL err_pulse: got err_o high 2 cycles want 1");
         end
      end
      if (arvalid === 1'b1 && !p_arv) begin
         ar_log.push_back(araddr);
         ar_rise_cyc = cyc;
      end

      arready = rd_pend ? 1'b0 : (rand_slv ? 1'($urandom_range(0, 1)) : 1'b1);
      if (rd_pend && rd_dly == 0) begin
         rvalid = 1; rdata = slave_data(rd_addr); rresp = slave_resp(rd_addr);
      end else begin
         rvalid = 0; rdata = $urandom; rresp = 2'b00;
      end
      if (stall_left > 0 && tvalid === 1'b1 && beat_idx == stall_beat) begin
         tready = 0;
         stall_left--;
         n_cmp++;
         if (tdata !== mem[stall_beat]) begin
            n_fail++;
            $display("FAIL stall_data: got %h want %h", tdata, mem[stall_beat]);
         end
      end else begin
         tready = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
      end

      arhs = arvalid && arready;
      rhs  = rvalid && rready;
      ths  = tvalid && tready;
      p_arv = arvalid; p_arhs = arhs; p_araddr = araddr;
      p_tv = tvalid; p_ths = ths; p_tdata = tdata; p_tlast = tlast; p_tuser = tuser;
      p_err = err;

      @(posedge aclk);
      cyc++;
      if (ths) begin
         beats.push_back({p_tuser, p_tlast, p_tdata});
         beat_idx++;
      end
      if (arhs) begin
         rd_pend = 1; rd_addr = p_araddr;
         rd_dly = rand_slv ? $urandom_range(0, 2) : 0;
         if (p_araddr != 32'h0) data_ar_hs = 1;
      end else if (rd_pend) begin
         if (rhs) begin
            rd_pend = 0; r_hs_count++; last_rhs_cyc = cyc;
         end else if (rd_dly > 0) begin
            rd_dly--;
         end
      end
   endtask

   // Runs one poll+packet and checks it against the packet-level expectation.
   task automatic run_pkt(input int len, input int bad, input int st_beat, input int st_cyc,
                          input bit rnd, input string tag);
      int  nb, exp_err, guard, start_rhs;
      bit  valid, bad_in;
      logic [33:0] exp_beat;
      status_word = {16'($urandom), 16'(len)};
      bad_word = bad; stall_beat = st_beat; stall_left = st_cyc; beat_idx = 0;
      rand_slv = rnd; rand_tready = rnd;
      beats.delete(); ar_log.delete(); err_seen = 0;

      valid   = (len != 0) && (len <= MAX_WORDS);
      bad_in  = valid && bad >= 0 && bad < len;
      nb      = !valid ? 0 : (bad_in ? bad + 1 : len);
      exp_err = (len > MAX_WORDS ? 1 : 0) + (bad_in ? 1 : 0);
      if (valid && !bad_in) exp_pkt = (exp_pkt + 1) % 65536;

      guard = 0;
      if (nb > 0) begin
         while (beats.size() < nb && guard < 3000) begin step(); guard++; end
      end else begin
         start_rhs = r_hs_count;
         while (r_hs_count == start_rhs && guard < 3000) begin step(); guard++; end
         repeat (3) step();
      end
      if (guard >= 3000) begin
         n_fail++;
         $display("FAIL %s timeout: got %0d beats want %0d", tag, beats.size(), nb);
      end
      #1;
      n_cmp++;
      if (beats.size() != nb) begin
         n_fail++;
         $display("FAIL %s beat_count: got %0d want %0d", tag, beats.size(), nb);
      end
      for (int i = 0; i < nb && i < beats.size(); i++) begin
         exp_beat = {(i == nb - 1) && bad_in, i == nb - 1, mem[i]};
         n_cmp++;
         if (beats[i] !== exp_beat) begin
            n_fail++;
            $display("FAIL %s beat%0d: got user/last/data=%h want %h", tag, i, beats[i], exp_beat);
         end
      end
      n_cmp++;
      if (ar_log.size() != nb + 1) begin
         n_fail++;
         $display("FAIL %s ar_count: got %0d want %0d", tag, ar_log.size(), nb + 1);
      end
      for (int i = 0; i < ar_log.size() && i <= nb; i++) begin
         n_cmp++;
         if (ar_log[i] !== 32'(4 * i)) begin
            n_fail++;
            $display("FAIL %s araddr%0d: got %h want %h", tag, i, ar_log[i], 32'(4 * i));
         end
      end
      n_cmp++;
      if (err_seen != exp_err) begin
         n_fail++;
         $display("FAIL %s err_pulses: got %0d want %0d", tag, err_seen, exp_err);
      end
      n_cmp++;
      if (pkt_cnt !== 16'(exp_pkt)) begin
         n_fail++;
         $display("FAIL %s pkt_cnt: got %0d want %0d", tag, pkt_cnt, exp_pkt);
      end
   endtask

   task automatic test_reset();
      aresetn = 0; enable = 1; arready = 1; rvalid = 1; rdata = 32'h5; rresp = 2'b00; tready = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         n_cmp++;
         if ({arvalid, rready, tvalid, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold: cycle %0d got arv/rr/tv/err=%b want 0000", i,
                     {arvalid, rready, tvalid, err});
         end
      end
      n_cmp++;
      if (araddr !== 32'h0 || pkt_cnt !== 16'd0 || tlast !== 1'b0 || tuser !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_vals: got addr=%h cnt=%0d last=%b user=%b want 0 0 0 0",
                  araddr, pkt_cnt, tlast, tuser);
      end
      enable = 0; aresetn = 1; arready = 0; rvalid = 0;
      clear_model();
      exp_pkt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         n_cmp++;
         if (arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled_idle: got arvalid=%b want 0", arvalid);
         end
      end
      enable = 1;
   endtask

   task automatic test_empty_poll();
      int guard;
      reset_dut();
      status_word = 32'h0; bad_word = -1; rand_slv = 0; rand_tready = 0;
      guard = 0;
      while (r_hs_count < 1 && guard < 200) begin step(); guard++; end
      guard = 0;
      while (ar_log.size() < 2 && guard < 200) begin step(); guard++; end
      n_cmp++;
      if (ar_log.size() < 2) begin
         n_fail++;
         $display("FAIL empty_repoll: got %0d ARs want 2", ar_log.size());
      end else begin
         n_cmp++;
         if (ar_rise_cyc - last_rhs_cyc != POLL_GAP + 2 && r_hs_count == 1) begin
            n_fail++;
            $display("FAIL empty_gap: got %0d cycles want %0d", ar_rise_cyc - last_rhs_cyc, POLL_GAP + 2);
         end
         n_cmp++;
         if (ar_log[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL empty_addr: got %h want 00000000", ar_log[1]);
         end
      end
      n_cmp++;
      if (err_seen != 0) begin
         n_fail++;
         $display("FAIL empty_err: got %0d pulses want 0", err_seen);
      end
   endtask

   task automatic test_basic();
      reset_dut();
      mem[0] = 32'hA1; mem[1] = 32'hA2; mem[2] = 32'hA3;
      run_pkt(3, -1, -1, 0, 0, "basic");
   endtask

   task automatic test_stall();
      reset_dut();
      mem[0] = 32'hA1; mem[1] = 32'hA2; mem[2] = 32'hA3;
      run_pkt(3, -1, 1, 10, 0, "stall");
   endtask

   task automatic test_rresp_err();
      int base, guard;
      reset_dut();
      for (int i = 0; i < 4; i++) mem[i] = $urandom;
      run_pkt(4, 1, -1, 0, 0, "rresp_err");
      base = ar_log.size();
      guard = 0;
      while (ar_log.size() <= base && guard < 100) begin step(); guard++; end
      n_cmp++;
      if (ar_log.size() <= base) begin
         n_fail++;
         $display("FAIL rresp_next_ar: got no AR want status poll");
      end else if (ar_log[base] !== 32'h0) begin
         n_fail++;
         $display("FAIL rresp_next_ar: got %h want 00000000", ar_log[base]);
      end
   endtask

   task automatic test_len_err();
      reset_dut();
      run_pkt(MAX_WORDS + 1, -1, -1, 0, 0, "len_err");
      run_pkt(MAX_WORDS > 8 ? 8 : MAX_WORDS, -1, -1, 0, 0, "after_len_err");
   endtask

   task automatic test_back_to_back();
      int len, bad;
      reset_dut();
      for (int k = 0; k < 8; k++) begin
         len = $urandom_range(0, 8);
         bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
         for (int i = 0; i < 8; i++) mem[i] = $urandom;
         run_pkt(len, bad, -1, 0, 1, "b2b");
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      reset_dut();
      for (int i = 0; i < 4; i++) mem[i] = $urandom;
      run_pkt(2, -1, -1, 0, 0, "pre_reset");
      status_word = 32'd4; bad_word = -1; rand_slv = 0; rand_tready = 0;
      data_ar_hs = 0;
      guard = 0;
      while (!data_ar_hs && guard < 200) begin step(); guard++; end
      @(negedge aclk);
      n_cmp++;
      if (rready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_in_data_r: got rready=%b want 1", rready);
      end
      aresetn = 0; arready = 0; rvalid = 0;
      @(posedge aclk);
      @(negedge aclk);
      n_cmp++;
      if ({arvalid, rready, tvalid, tlast, tuser, err} !== 6'b0 || araddr !== 32'h0 || pkt_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got arv/rr/tv/tl/tu/err=%b addr=%h cnt=%0d want 000000 0 0",
                  {arvalid, rready, tvalid, tlast, tuser, err}, araddr, pkt_cnt);
      end
      aresetn = 1;
      clear_model();
      exp_pkt = 0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      test_reset();
      test_empty_poll();
      test_basic();
      test_stall();
      test_rresp_err();
      test_len_err();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion want finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
